// File: rtl/os_ctrl_pkg.sv
// Shared types and helpers for the output-stationary array sequencer.
// Holds the FSM state enum, counter sizing and default geometry.
package os_ctrl_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_KW = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FEED,
      S_DRAIN,
      S_DONE
   } state_t;

   // Feed counter width: covers k_len + 2N - 2 without wrapping.
   function automatic int cnt_w(input int n, input int kw);
      return kw + $clog2(2 * n) + 1;
   endfunction

endpackage

// File: rtl/os_skew_gen.sv
// Skewed operand-buffer enable/address generator for one array edge.
// Lane g is live for g <= t < g + k_len and reads index t - g.
module os_skew_gen
   import os_ctrl_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int KW = DEF_KW,
   parameter int CW = cnt_w(N, KW)
) (
   input  logic [CW-1:0]   t,
   input  logic [KW-1:0]   k_len,
   output logic [N-1:0]    en,
   output logic [N*KW-1:0] addr
);

   for (genvar g = 0; g < N; g++) begin : g_lane
      localparam logic [CW-1:0] IDX = CW'(g);
      logic [CW-1:0] w_hi;
      logic [CW-1:0] w_off;

      assign w_hi  = IDX + CW'(k_len);
      assign w_off = t - IDX;
      assign en[g] = (t >= IDX) && (t < w_hi);
      assign addr[g*KW +: KW] = en[g] ? w_off[KW-1:0] : '0;
   end

endmodule

// File: rtl/os_array_ctrl.sv
// Sequencer for an NxN output-stationary systolic array.
// Clears, feeds skewed operands over K, then drains result rows.
module os_array_ctrl
   import os_ctrl_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int KW = DEF_KW
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [KW-1:0]        k_len,
   output logic                 busy,
   output logic                 done,
   output logic                 rstnPipe,
   output logic                 rstnPsum,
   output logic [N-1:0]         a_en,
   output logic [N*KW-1:0]      a_addr,
   output logic [N-1:0]         b_en,
   output logic [N*KW-1:0]      b_addr,
   output logic                 res_valid,
   output logic [$clog2(N)-1:0] res_row
);

   localparam int CW = cnt_w(N, KW);
   localparam int RW = $clog2(N);

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_t;
   logic [RW-1:0] r_row;
   logic [KW-1:0] r_k;
   logic          r_rst;

   logic          w_accept;
   logic [CW-1:0] w_f_last;
   logic [KW-1:0] w_k_eff;

   assign w_accept = start &&
                     (r_state == S_IDLE || r_state == S_DONE);
   assign w_f_last = CW'(r_k) + CW'(2 * N - 3);
   // Zero K outside FEED so every lane reads as disabled.
   assign w_k_eff  = (r_state == S_FEED) ? r_k : '0;

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Feed/drain counters, latched K and reset-seen flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_t   <= '0;
         r_row <= '0;
         r_k   <= '0;
         r_rst <= 1'b1;
      end else begin
         r_rst <= 1'b0;
         if (w_accept) r_k <= k_len;
         r_t   <= (r_state == S_FEED)  ? r_t + CW'(1)   : '0;
         r_row <= (r_state == S_DRAIN) ? r_row + RW'(1) : '0;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = start ? S_CLEAR : S_IDLE;
         S_CLEAR: w_next = (r_k != '0) ? S_FEED : S_DRAIN;
         S_FEED:  if (r_t == w_f_last) w_next = S_DRAIN;
         S_DRAIN: if (r_row == RW'(N - 1)) w_next = S_DONE;
         S_DONE:  w_next = start ? S_CLEAR : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode from registered state only.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      rstnPipe  = 1'b0;
      rstnPsum  = !r_rst;
      res_valid = 1'b0;
      res_row   = '0;
      unique case (r_state)
         S_IDLE:  ;
         S_CLEAR: begin
            busy     = 1'b1;
            rstnPsum = 1'b0;
         end
         S_FEED: begin
            busy     = 1'b1;
            rstnPipe = 1'b1;
         end
         S_DRAIN: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            res_row   = r_row;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   os_skew_gen #(.N(N), .KW(KW), .CW(CW)) u_skew_a (
      .t     (r_t),
      .k_len (w_k_eff),
      .en    (a_en),
      .addr  (a_addr)
   );

   os_skew_gen #(.N(N), .KW(KW), .CW(CW)) u_skew_b (
      .t     (r_t),
      .k_len (w_k_eff),
      .en    (b_en),
      .addr  (b_addr)
   );

endmodule

// File: tb/tb_os_array_ctrl.sv
// Self-checking bench for os_array_ctrl.
// Job-level timing model plus directed tables and sequences.
module tb_os_array_ctrl;

   localparam int N  = 4;
   localparam int KW = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic          busy, done, rstnPipe, rstnPsum, res_valid;
   logic [N-1:0]  a_en, b_en;
   logic [N*KW-1:0] a_addr, b_addr;
   logic [1:0]    res_row;

   logic        rstn2 = 1'b0;
   logic        start2 = 1'b0;
   logic [3:0]  k2 = '0;
   logic        busy2, done2, pipe2, psum2, rv2;
   logic [1:0]  a_en2, b_en2;
   logic [7:0]  a_addr2, b_addr2;
   logic [0:0]  row2;

   always #5 clk = ~clk;

   os_array_ctrl #(.N(N), .KW(KW)) u_dut (
      .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
      .busy(busy), .done(done), .rstnPipe(rstnPipe),
      .rstnPsum(rstnPsum), .a_en(a_en), .a_addr(a_addr),
      .b_en(b_en), .b_addr(b_addr), .res_valid(res_valid),
      .res_row(res_row)
   );

   os_array_ctrl #(.N(2), .KW(4)) u_dut2 (
      .clk(clk), .rstn(rstn2), .start(start2), .k_len(k2),
      .busy(busy2), .done(done2), .rstnPipe(pipe2),
      .rstnPsum(psum2), .a_en(a_en2), .a_addr(a_addr2),
      .b_en(b_en2), .b_addr(b_addr2), .res_valid(rv2),
      .res_row(row2)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---- job-level reference model ----
   function automatic int f_of(input int k);
      return (k == 0) ? 0 : k + 2 * N - 2;
   endfunction

   function automatic int end_rel(input int k);
      return f_of(k) + N + 2;
   endfunction

   bit m_act = 0;
   bit m_rst = 1;
   int m_rel = 0;
   int m_k = 0;
   bit m_idle;
   int m_f, m_t;
   logic [78:0] e_vec, a_vec;
   logic e_busy, e_done, e_pipe, e_psum, e_rv;
   logic [1:0] e_row;
   logic [N-1:0] e_aen;
   logic [N*KW-1:0] e_addr;

   always @(posedge clk) begin
      m_idle = !m_act || (m_rel == end_rel(m_k));
      if (!rstn) begin
         m_act = 0;
         m_rst = 1;
      end else begin
         m_rst = 0;
         if (m_idle && start) begin
            m_act = 1;
            m_rel = 1;
            m_k = int'(k_len);
         end else if (m_act) begin
            if (m_rel == end_rel(m_k)) m_act = 0;
            else m_rel++;
         end
      end
      #1;
      e_busy = 0; e_done = 0; e_pipe = 0; e_rv = 0;
      e_psum = !m_rst; e_row = '0; e_aen = '0; e_addr = '0;
      if (m_act) begin
         m_f = f_of(m_k);
         if (m_rel == 1) begin
            e_busy = 1;
            e_psum = 0;
         end else if (m_rel <= m_f + 1) begin
            e_busy = 1;
            e_pipe = 1;
            m_t = m_rel - 2;
            for (int i = 0; i < N; i++)
               if (i <= m_t && m_t < i + m_k) begin
                  e_aen[i] = 1'b1;
                  e_addr[i*KW +: KW] = KW'(m_t - i);
               end
         end else if (m_rel <= m_f + N + 1) begin
            e_busy = 1;
            e_rv = 1;
            e_row = 2'(m_rel - m_f - 2);
         end else begin
            e_done = 1;
         end
      end
      e_vec = {e_busy, e_done, e_pipe, e_psum, e_aen, e_aen,
               e_rv, e_row, e_addr, e_addr};
      a_vec = {busy, done, rstnPipe, rstnPsum, a_en, b_en,
               res_valid, res_row, a_addr, b_addr};
      check("cycle_outputs", 128'(a_vec), 128'(e_vec));
   end

   // ---- directed helpers ----
   typedef struct {
      int k;
      int exp_done;
      int exp_rv;
   } vec_t;

   vec_t tbl[5];

   task automatic run_job(input int k, output int done_rel,
                          output int first_rv);
      start = 1'b1;
      k_len = KW'(k);
      done_rel = -1;
      first_rv = -1;
      for (int r = 1; r <= 600 && done_rel < 0; r++) begin
         @(negedge clk);
         start = 1'b0;
         if (res_valid && first_rv < 0) first_rv = r;
         if (done) done_rel = r;
      end
   endtask

   int d_rel, v_rel;

   initial begin
      tbl[0] = '{3, 15, 11};
      tbl[1] = '{0, 6, 2};
      tbl[2] = '{1, 13, 9};
      tbl[3] = '{5, 17, 13};
      tbl[4] = '{255, 267, 263};

      repeat (3) @(negedge clk);
      check("reset_busy", 128'({busy, done, res_valid}), 128'(0));
      check("reset_lanes", 128'({a_en, b_en, a_addr, b_addr}), 128'(0));
      rstn = 1'b1;
      rstn2 = 1'b1;
      @(negedge clk);
      check("idle_ctrl", 128'({rstnPipe, rstnPsum}), 128'(2'b01));

      // back-to-back jobs from the table
      for (int i = 0; i < 5; i++) begin
         run_job(tbl[i].k, d_rel, v_rel);
         check($sformatf("done_rel_k%0d", tbl[i].k),
               128'(d_rel), 128'(tbl[i].exp_done));
         check($sformatf("rv_rel_k%0d", tbl[i].k),
               128'(v_rel), 128'(tbl[i].exp_rv));
      end
      @(negedge clk);

      // starts during a job are ignored; start in DONE restarts
      start = 1'b1;
      k_len = 8'd3;
      d_rel = -1;
      for (int r = 1; r <= 40 && d_rel < 0; r++) begin
         @(negedge clk);
         start = (r == 3 || r == 8);
         k_len = start ? 8'd7 : 8'd3;
         if (r == 4)
            check("a2_cycle4", 128'({a_en[2], a_addr[16 +: 8]}),
                  128'({1'b1, 8'd0}));
         if (r == 5)
            check("b3_cycle5", 128'(b_en[3]), 128'(1));
         if (done) d_rel = r;
      end
      check("ignored_start_done", 128'(d_rel), 128'(15));
      start = 1'b1;
      k_len = 8'd2;
      @(negedge clk);
      start = 1'b0;
      check("b2b_clear", 128'({busy, rstnPsum, rstnPipe}),
            128'(3'b100));
      for (int r = 0; r < 40 && !done; r++) @(negedge clk);
      check("b2b_done", 128'(done), 128'(1));
      @(negedge clk);

      // reset mid-FEED
      start = 1'b1;
      k_len = 8'd3;
      for (int r = 1; r <= 9; r++) begin
         @(negedge clk);
         start = 1'b0;
         rstn = (r != 7);
         if (r == 8)
            check("rst_outputs",
                  128'({busy, a_en, b_en, rstnPipe, rstnPsum}),
                  128'(0));
         if (r == 9)
            check("rst_psum_back", 128'({busy, rstnPsum}),
                  128'(2'b01));
      end
      run_job(4, d_rel, v_rel);
      check("post_rst_done", 128'(d_rel), 128'(16));

      // randomized traffic against the model
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         k_len = KW'($urandom_range(0, 12));
         rstn = ($urandom_range(0, 59) != 0);
      end
      rstn = 1'b1;
      start = 1'b0;
      @(negedge clk);

      // N=2, KW=4, K=15 boundary
      start2 = 1'b1;
      k2 = 4'd15;
      d_rel = -1;
      for (int r = 1; r <= 40 && d_rel < 0; r++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (r == 16)
            check("n2_row0_last", 128'({a_en2, a_addr2[3:0]}),
                  128'({2'b11, 4'd14}));
         if (r == 17)
            check("n2_row1_last", 128'({a_en2, a_addr2[7:4]}),
                  128'({2'b10, 4'd14}));
         if (r == 18)
            check("n2_feed_end", 128'({a_en2, b_en2, pipe2}),
                  128'({2'b00, 2'b00, 1'b1}));
         if (done2) d_rel = r;
      end
      check("n2_done_rel", 128'(d_rel), 128'(21));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
